// File: rtl/shift_reg_universal_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_reg_universal_if : command/status bundle for the universal shift register
// Revision 1.0
// ---------------------------------------------------------------------------
interface shift_reg_universal_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output clear, en, mode, d, sin, start,
    input  q, sout, busy, done
  );

  modport slave (
    input  clear, en, mode, d, sin, start,
    output q, sout, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shift_reg_universal.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_reg_universal : WIDTH-bit universal shift register with burst serializer
// Revision 1.0
// ---------------------------------------------------------------------------
module shift_reg_universal #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  shift_reg_universal_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] C_MODE_LOAD = 3'd1;
  localparam logic [2:0] C_MODE_SHL  = 3'd2;
  localparam logic [2:0] C_MODE_SHR  = 3'd3;
  localparam logic [2:0] C_MODE_ROTL = 3'd4;
  localparam logic [2:0] C_MODE_ROTR = 3'd5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_burst_next;
  logic [WIDTH-1:0] w_mode_next;
  logic             w_sout;

  // The burst always shifts toward the serial tap so bits leave in order.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_burst_next = {bus.sin, r_q[WIDTH-1:1]};
      assign w_sout       = r_q[0];
    end else begin : g_msb_first
      assign w_burst_next = {r_q[WIDTH-2:0], bus.sin};
      assign w_sout       = r_q[WIDTH-1];
    end
  endgenerate

  always_comb begin
    w_mode_next = r_q;
    case (bus.mode)
      C_MODE_LOAD: w_mode_next = bus.d;
      C_MODE_SHL:  w_mode_next = {r_q[WIDTH-2:0], bus.sin};
      C_MODE_SHR:  w_mode_next = {bus.sin, r_q[WIDTH-1:1]};
      C_MODE_ROTL: w_mode_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      C_MODE_ROTR: w_mode_next = {r_q[0], r_q[WIDTH-1:1]};
      default:     w_mode_next = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_q     <= '0;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_q     <= w_burst_next;
        r_count <= r_count - CW'(1);
        if (r_count == CW'(1)) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      end else if (bus.start) begin
        r_q     <= bus.d;
        r_count <= CW'(WIDTH);
        r_busy  <= 1'b1;
        r_state <= SHIFT;
      end else if (bus.en) begin
        r_q <= w_mode_next;
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.sout = w_sout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule
`default_nettype wire
